bus_rr_router_n: RTL and testbench

//  Parametrised N-port bus arbiter/router; successor of the bs_gnrtr_n_rbtr bus under test.

---
 rtl/bus_rr_router_n.sv | 145 ++++++++++++++
 tb/tb_bus_rr_router_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_router_n.sv
// N-port bus arbiter/router: grants one pending source per transfer and delivers its
// packet by destination ID (unicast or broadcast). Optional counters: BUS_RR_STATS_EN.
module bus_rr_router_n #(
   parameter int         DRVRS     = 4,
   parameter int         PCKG_SZ   = 16,
   parameter logic [7:0] BROADCAST = 8'hFF,
   parameter int         ARB_MODE  = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DRVRS-1:0]           pndng,
   input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
   output logic [DRVRS-1:0]           pop,
   output logic [DRVRS-1:0]           push,
   output logic [DRVRS*PCKG_SZ-1:0]   D_push,
   output logic                       busy,
`ifdef BUS_RR_STATS_EN
   output logic [15:0]                pkt_cnt,
   output logic [15:0]                drop_cnt,
`endif
   output logic [1:0]                 state_dbg
);

   localparam int PW = $clog2(DRVRS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ROUTE = 2'd2
   } state_t;

   state_t                      state, state_nxt;
   logic [PW-1:0]               rr_ptr;
   logic [PW-1:0]               grant_idx;
   logic [PW-1:0]               win_idx;
   logic                        win_vld;
   logic [PCKG_SZ-1:0]          lane_sel;
   logic [7:0]                  dest;
   logic [DRVRS-1:0]            push_rt;
   logic [DRVRS-1:0]            pop_nxt;
   logic [DRVRS-1:0]            push_nxt;
   logic [DRVRS*PCKG_SZ-1:0]    dpush_nxt;

   assign state_dbg = state;

   // Winner selection; loops run from the lowest-priority candidate so the last hit wins.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_idx = '0;
      if (ARB_MODE == 1) begin
         for (int i = DRVRS - 1; i >= 0; i--) begin
            if (pndng[i]) begin
               win_vld = 1'b1;
               win_idx = PW'(i);
            end
         end
      end else begin
         for (int k = DRVRS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % DRVRS;
            if (pndng[idx]) begin
               win_vld = 1'b1;
               win_idx = PW'(idx);
            end
         end
      end
   end

   assign lane_sel = D_pop[grant_idx*PCKG_SZ +: PCKG_SZ];
   assign dest     = lane_sel[PCKG_SZ-1 -: 8];

   // Broadcast is matched before the range check; out-of-range or self-addressed drops.
   always_comb begin
      push_rt = '0;
      for (int j = 0; j < DRVRS; j++) begin
         if (dest == BROADCAST)
            push_rt[j] = (j != int'(grant_idx));
         else
            push_rt[j] = (int'(dest) == j) && (j != int'(grant_idx));
      end
   end

   always_comb begin
      state_nxt = state;
      pop_nxt   = '0;
      push_nxt  = '0;
      dpush_nxt = '0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt        = GRANT;
               pop_nxt[win_idx] = 1'b1;
            end
         end
         GRANT: begin
            state_nxt = ROUTE;
            push_nxt  = push_rt;
            for (int j = 0; j < DRVRS; j++)
               dpush_nxt[j*PCKG_SZ +: PCKG_SZ] = push_rt[j] ? lane_sel : '0;
         end
         ROUTE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pop       <= '0;
         push      <= '0;
         D_push    <= '0;
         busy      <= 1'b0;
         rr_ptr    <= PW'(DRVRS - 1);
         grant_idx <= '0;
      end else begin
         state  <= state_nxt;
         pop    <= pop_nxt;
         push   <= push_nxt;
         D_push <= dpush_nxt;
         busy   <= (state_nxt != IDLE);
         if (state == IDLE && win_vld) begin
            grant_idx <= win_idx;
            rr_ptr    <= win_idx;
         end
      end
   end

`ifdef BUS_RR_STATS_EN
   // In ROUTE the registered push mask tells whether the packet went anywhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else if (state == ROUTE) begin
         if (|push) begin
            if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
         end else begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bus_rr_router_n.sv
// Randomized bench for bus_rr_router_n: a round-robin and a fixed-priority instance share
// stimulus and are compared against a transaction-level reference model.
module tb_bus_rr_router_n;
   localparam int N = 4;
   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic [N-1:0]   pndng;
   logic [N*W-1:0] d_pop;
   logic [N-1:0]   pop_r, push_r, pop_f, push_f;
   logic [N*W-1:0] dpush_r, dpush_f;
   logic           busy_r, busy_f;
   logic [1:0]     st_r, st_f;
`ifdef BUS_RR_STATS_EN
   logic [15:0]    pkt_r, drop_r, pkt_f, drop_f;
   int             pkt_m, drop_m;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int last_rr;
   logic [N*W-1:0] exp_q[$];

   bus_rr_router_n #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .ARB_MODE(0)) dut_rr (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
      .pop(pop_r), .push(push_r), .D_push(dpush_r), .busy(busy_r),
`ifdef BUS_RR_STATS_EN
      .pkt_cnt(pkt_r), .drop_cnt(drop_r),
`endif
      .state_dbg(st_r));

   bus_rr_router_n #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .ARB_MODE(1)) dut_fp (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
      .pop(pop_f), .push(push_f), .D_push(dpush_f), .busy(busy_f),
`ifdef BUS_RR_STATS_EN
      .pkt_cnt(pkt_f), .drop_cnt(drop_f),
`endif
      .state_dbg(st_f));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Round-robin reference: candidates listed in rotated order after the last grant.
   function automatic int model_rr(input logic [N-1:0] p, input int last);
      int order[$];
      for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
      foreach (order[i]) if (p[order[i]]) return order[i];
      return -1;
   endfunction

   function automatic int model_fp(input logic [N-1:0] p);
      for (int i = 0; i < N; i++) if (p[i]) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] model_mask(input int g, input logic [W-1:0] pkt);
      logic [7:0] d;
      logic [N-1:0] m;
      d = pkt[W-1:W-8];
      m = '0;
      if (d == 8'hFF) begin
         for (int j = 0; j < N; j++) if (j != g) m[j] = 1'b1;
      end else if (int'(d) < N && int'(d) != g) begin
         m[int'(d)] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [N*W-1:0] model_lanes(input logic [N-1:0] m, input logic [W-1:0] pkt);
      logic [N*W-1:0] l;
      l = '0;
      for (int j = 0; j < N; j++) if (m[j]) l[j*W +: W] = pkt;
      return l;
   endfunction

   function automatic logic [W-1:0] rand_pkt();
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      if (r < 4)       d = 8'(r);
      else if (r < 6)  d = 8'hFF;
      else             d = 8'($urandom_range(4, 254));
      return {d, 8'($urandom_range(0, 255))};
   endfunction

   function automatic logic [N*W-1:0] rand_lanes();
      logic [N*W-1:0] l;
      for (int j = 0; j < N; j++) l[j*W +: W] = rand_pkt();
      return l;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_pop_rr"}, pop_r, 0);
      check({tag, "_push_rr"}, push_r, 0);
      check({tag, "_dpush_rr"}, dpush_r, 0);
      check({tag, "_busy_rr"}, busy_r, 0);
      check({tag, "_pop_fp"}, pop_f, 0);
      check({tag, "_push_fp"}, push_f, 0);
      check({tag, "_busy_fp"}, busy_f, 0);
   endtask

   // Called at a negedge with both DUTs idle; returns at a negedge with both idle again.
   task automatic run_txn(input logic [N-1:0] p, input logic [N*W-1:0] lanes);
      int gr, gf;
      logic [N-1:0] mr, mf;
      logic [N*W-1:0] exp_f;
      pndng = p;
      d_pop = lanes;
      if (p == '0) begin
         @(negedge clk);
         check_quiet("nopend");
         return;
      end
      gr = model_rr(p, last_rr);
      gf = model_fp(p);
      mr = model_mask(gr, lanes[gr*W +: W]);
      mf = model_mask(gf, lanes[gf*W +: W]);
      exp_q.push_back(model_lanes(mr, lanes[gr*W +: W]));
      exp_f = model_lanes(mf, lanes[gf*W +: W]);
      @(negedge clk);
      check("grant_pop_rr", pop_r, 64'(1) << gr);
      check("grant_pop_fp", pop_f, 64'(1) << gf);
      check("grant_push_rr", push_r, 0);
      check("grant_busy_rr", busy_r, 1);
      last_rr = gr;
      pndng = N'($urandom_range(0, 15));
      @(negedge clk);
      check("route_pop_rr", pop_r, 0);
      check("route_push_rr", push_r, mr);
      check("route_dpush_rr", dpush_r, exp_q.pop_front());
      check("route_push_fp", push_f, mf);
      check("route_dpush_fp", dpush_f, exp_f);
      check("route_busy_rr", busy_r, 1);
      check("route_busy_fp", busy_f, 1);
`ifdef BUS_RR_STATS_EN
      if (mr == '0) drop_m++; else pkt_m++;
`endif
      pndng = N'($urandom_range(0, 15));
      d_pop = rand_lanes();
      @(negedge clk);
      check("idle_push_rr", push_r, 0);
      check("idle_pop_rr", pop_r, 0);
      check("idle_busy_rr", busy_r, 0);
      check("idle_state_rr", st_r, 0);
`ifdef BUS_RR_STATS_EN
      check("pkt_cnt", pkt_r, pkt_m);
      check("drop_cnt", drop_r, drop_m);
`endif
   endtask

   initial begin
      logic [N*W-1:0] l;
      reset   = 1'b1;
      pndng   = 4'hF;
      d_pop   = rand_lanes();
      last_rr = N - 1;
`ifdef BUS_RR_STATS_EN
      pkt_m = 0;
      drop_m = 0;
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_quiet("reset");
      end
      reset = 1'b0;

      // Round-robin sweep from reset: 0,1,2,3,0; fixed priority always picks 0.
      for (int i = 0; i < 5; i++) run_txn(4'hF, rand_lanes());

      l = rand_lanes();
      l[1*W +: W] = 16'h0208;
      run_txn(4'b0010, l);
      l = rand_lanes();
      l[0*W +: W] = 16'hFF55;
      run_txn(4'b0001, l);
      l = rand_lanes();
      l[2*W +: W] = 16'h07A5;
      run_txn(4'b0100, l);
      l = rand_lanes();
      l[3*W +: W] = 16'h033C;
      run_txn(4'b1000, l);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) run_txn('0, rand_lanes());
         else run_txn(N'($urandom_range(1, 15)), rand_lanes());
      end

      // Reset while a grant is outstanding: packet is lost and the pointer returns home.
      pndng = 4'b0100;
      d_pop = rand_lanes();
      @(negedge clk);
      check("rst_grant_pop", pop_r, 4'b0100);
      reset = 1'b1;
      @(negedge clk);
      check_quiet("rst_mid");
      check("rst_mid_state", st_r, 0);
      reset = 1'b0;
      last_rr = N - 1;
`ifdef BUS_RR_STATS_EN
      pkt_m = 0;
      drop_m = 0;
      check("rst_pkt_cnt", pkt_r, 0);
`endif
      run_txn(4'hF, rand_lanes());
      run_txn(4'hF, rand_lanes());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
